// File: rtl/fetch_queue.sv
// Instruction-fetch queue: line-sized bus reads into a circular byte buffer,
// presenting a byte-0-aligned decode window with variable per-cycle retire.
//
// state | meaning
// IDLE  | no request outstanding; request a line when occupancy is low
// REQ   | request presented on the bus, waiting for acceptance
// RECV  | burst in flight, beats written (or skipped up to the fetch RIP)
// DRAIN | burst in flight after a redirect, beats discarded
module fetch_queue #(
    parameter int DEPTH_BYTES      = 128,
    parameter int BEAT_BYTES       = 8,
    parameter int LINE_BYTES       = 64,
    parameter int WINDOW_BYTES     = 15,
    parameter int REFILL_THRESHOLD = 32
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [63:0]                       entry,
    input  logic                              redirect_valid,
    input  logic [63:0]                       redirect_rip,
    output logic                              req_valid,
    output logic [63:0]                       req_addr,
    input  logic                              req_ack,
    input  logic                              resp_valid,
    input  logic [BEAT_BYTES*8-1:0]           resp_data,
    output logic                              resp_ack,
    output logic [WINDOW_BYTES*8-1:0]         window,
    output logic [$clog2(WINDOW_BYTES+1)-1:0] window_valid_bytes,
    output logic [63:0]                       window_rip,
    input  logic [$clog2(WINDOW_BYTES+1)-1:0] consume
);

    localparam int PTR_W = $clog2(DEPTH_BYTES);
    localparam int CNT_W = $clog2(DEPTH_BYTES + 1);
    localparam int WV_W  = $clog2(WINDOW_BYTES + 1);
    localparam int BEATS = LINE_BYTES / BEAT_BYTES;
    localparam int BC_W  = $clog2(BEATS + 1);
    localparam int BY_W  = $clog2(BEAT_BYTES + 1);

    typedef enum logic [1:0] {IDLE, REQ, RECV, DRAIN} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [63:0]       fetch_line_q, fetch_line_d;
    logic [63:0]       rip_q, rip_d;
    logic [BC_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [BC_W-1:0]   beat_skip_q, beat_skip_d;
    logic [BY_W-1:0]   byte_skip_q, byte_skip_d;
    logic              req_valid_q, req_valid_d;
    logic              write_en;
    logic              beat_last;
    logic [CNT_W-1:0]  added;
    logic [7:0]        mem_q [DEPTH_BYTES];

    function automatic logic [63:0] line_of(input logic [63:0] r);
        return r & ~64'(LINE_BYTES - 1);
    endfunction

    function automatic logic [BC_W-1:0] beat_skip_of(input logic [63:0] r);
        return BC_W'((r & 64'(LINE_BYTES - 1)) / 64'(BEAT_BYTES));
    endfunction

    function automatic logic [BY_W-1:0] byte_skip_of(input logic [63:0] r);
        return BY_W'(r & 64'(BEAT_BYTES - 1));
    endfunction

    assign req_valid  = req_valid_q;
    assign req_addr   = fetch_line_q;
    assign resp_ack   = resp_valid;
    assign window_rip = rip_q;
    assign window_valid_bytes = (count_q < CNT_W'(WINDOW_BYTES)) ? WV_W'(count_q)
                                                                  : WV_W'(WINDOW_BYTES);

    // Decode window: bytes from rd_ptr onwards, wrapping around the buffer.
    always_comb begin
        window = '0;
        for (int i = 0; i < WINDOW_BYTES; i++) begin
            window[8*i +: 8] = mem_q[PTR_W'(rd_ptr_q + PTR_W'(i))];
        end
    end

    // Next-state: fetch FSM, restart on redirect, beat write and retire accounting.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        fetch_line_d = fetch_line_q;
        rip_d        = rip_q;
        beat_cnt_d   = beat_cnt_q;
        beat_skip_d  = beat_skip_q;
        byte_skip_d  = byte_skip_q;
        req_valid_d  = req_valid_q;
        write_en     = 1'b0;
        added        = '0;
        beat_last    = resp_valid && (beat_cnt_q == BC_W'(BEATS - 1));

        if (redirect_valid) begin
            count_d      = '0;
            rd_ptr_d     = '0;
            wr_ptr_d     = '0;
            rip_d        = redirect_rip;
            fetch_line_d = line_of(redirect_rip);
            beat_skip_d  = beat_skip_of(redirect_rip);
            byte_skip_d  = byte_skip_of(redirect_rip);
            req_valid_d  = 1'b0;
            case (state_q)
                RECV, DRAIN: begin
                    // Beats of the abandoned burst still count towards its length.
                    if (resp_valid) beat_cnt_d = beat_cnt_q + BC_W'(1);
                    state_d = beat_last ? IDLE : DRAIN;
                end
                REQ: begin
                    if (req_ack) begin
                        state_d    = DRAIN;
                        beat_cnt_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else begin
            case (state_q)
                IDLE: begin
                    if (count_q < CNT_W'(REFILL_THRESHOLD)) begin
                        state_d     = REQ;
                        req_valid_d = 1'b1;
                    end
                end
                REQ: begin
                    if (req_ack) begin
                        state_d     = RECV;
                        req_valid_d = 1'b0;
                        beat_cnt_d  = '0;
                    end
                end
                RECV: begin
                    if (resp_valid) begin
                        beat_cnt_d = beat_cnt_q + BC_W'(1);
                        if (beat_skip_q != '0) beat_skip_d = beat_skip_q - BC_W'(1);
                        else                   write_en    = 1'b1;
                        if (beat_last) begin
                            state_d      = IDLE;
                            fetch_line_d = fetch_line_q + 64'(LINE_BYTES);
                        end
                    end
                end
                DRAIN: begin
                    if (resp_valid) begin
                        beat_cnt_d = beat_cnt_q + BC_W'(1);
                        if (beat_last) state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase

            if (write_en) begin
                added       = CNT_W'(BEAT_BYTES) - CNT_W'(byte_skip_q);
                wr_ptr_d    = wr_ptr_q + PTR_W'(BEAT_BYTES);
                byte_skip_d = '0;
            end
            count_d = count_q + added - CNT_W'(consume);
            rip_d   = rip_q + 64'(consume);
            // First written beat after a restart starts the window mid-beat.
            if (write_en && byte_skip_q != '0) rd_ptr_d = PTR_W'(byte_skip_q);
            else                               rd_ptr_d = rd_ptr_q + PTR_W'(consume);
        end
    end

    // Control and pointer registers with synchronous restart at the entry RIP.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            count_q      <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            rip_q        <= entry;
            fetch_line_q <= line_of(entry);
            beat_cnt_q   <= '0;
            beat_skip_q  <= beat_skip_of(entry);
            byte_skip_q  <= byte_skip_of(entry);
            req_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            rip_q        <= rip_d;
            fetch_line_q <= fetch_line_d;
            beat_cnt_q   <= beat_cnt_d;
            beat_skip_q  <= beat_skip_d;
            byte_skip_q  <= byte_skip_d;
            req_valid_q  <= req_valid_d;
        end
    end

    // Byte storage; a whole beat lands at the beat-aligned write pointer.
    always_ff @(posedge clk) begin
        if (!reset && write_en) begin
            for (int b = 0; b < BEAT_BYTES; b++) begin
                mem_q[PTR_W'(wr_ptr_q + PTR_W'(b))] <= resp_data[8*b +: 8];
            end
        end
    end

    // Protocol checks on the decoder and bus sides.
    always_ff @(posedge clk) begin
        if (!reset && !redirect_valid) begin
            assert (consume <= window_valid_bytes)
                else $fatal(1, "fetch_queue: consume beyond valid window bytes");
        end
        if (!reset) begin
            assert (!resp_valid || state_q == RECV || state_q == DRAIN)
                else $fatal(1, "fetch_queue: response beat with no request outstanding");
        end
    end

endmodule
